// File: rtl/pb_sink_pkg.sv
// rtl/pb_sink_pkg.sv - shared FSM state encoding and counter width for the Port B sink
package pb_sink_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    LATCH   = 3'd2,
    ACK     = 3'd3,
    WAIT_HI = 3'd4,
    BUSY    = 3'd5
  } state_t;

endpackage

// File: rtl/pb_handshake_sink_if.sv
// rtl/pb_handshake_sink_if.sv - PPI Port B strobe handshake plus local FIFO read port
interface pb_handshake_sink_if;

  logic [7:0] pb;
  logic       obf_n;
  logic       ack_n;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;

  modport master (
    output pb, obf_n, rd_en,
    input  ack_n, rd_data, empty, full
  );

  modport slave (
    input  pb, obf_n, rd_en,
    output ack_n, rd_data, empty, full
  );

endinterface

// File: rtl/pb_sink_fifo.sv
// rtl/pb_sink_fifo.sv - first-word-fall-through byte FIFO with occupancy count
module pb_sink_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_empty,
  output logic             o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign w_push    = i_wr_en && !o_full;
  assign w_pop     = i_rd_en && !o_empty;
  // Head is gated so the output reads zero whenever nothing valid is held.
  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

endmodule

// File: rtl/pb_handshake_sink.sv
// rtl/pb_handshake_sink.sv - printer-like consumer of the PPI Port B mode 1 strobed output
module pb_handshake_sink
  import pb_sink_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int SETUP_CYC   = 2,
  parameter int ACK_CYC     = 4,
  parameter int BUSY_CYC    = 8,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  pb_handshake_sink_if.slave        bus,
  output logic                      o_busy,
  output logic [15:0]               o_byte_cnt,
  output logic                      o_err
);

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] ACK_LD   = CNT_W'(ACK_CYC - 1);
  localparam logic [CNT_W-1:0] BUSY_LD  = CNT_W'(BUSY_CYC);
  localparam logic [CNT_W-1:0] TO_LD    = CNT_W'(TIMEOUT_CYC - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ack_n;
  logic             r_busy;
  logic             r_err;
  logic [15:0]      r_byte_cnt;
  logic             r_obf_m;
  logic             r_obf_s;
  logic             w_wr_en;
  logic             w_full;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_obf_m <= 1'b1;
      r_obf_s <= 1'b1;
    end else begin
      r_obf_m <= bus.obf_n;
      r_obf_s <= r_obf_m;
    end
  end

  assign w_wr_en = (r_state == LATCH);

  // r_busy is assigned together with every state change so it tracks state != IDLE.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_ack_n    <= 1'b1;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_byte_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!r_obf_s && !w_full) begin
            r_state <= SETUP;
            r_cnt   <= SETUP_LD;
            r_busy  <= 1'b1;
          end
        end
        SETUP: begin
          if (r_cnt == '0) r_state <= LATCH;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        LATCH: begin
          r_byte_cnt <= r_byte_cnt + 1'b1;
          r_state    <= ACK;
          r_cnt      <= ACK_LD;
          r_ack_n    <= 1'b0;
        end
        ACK: begin
          if (r_cnt == '0) begin
            r_state <= WAIT_HI;
            r_ack_n <= 1'b1;
            r_cnt   <= TO_LD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        WAIT_HI: begin
          if (r_obf_s) begin
            if (BUSY_CYC == 0) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= BUSY;
              r_cnt   <= BUSY_LD;
            end
          end else if (r_cnt == '0) begin
            r_err   <= 1'b1;
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        BUSY: begin
          if (r_cnt == '0) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ack_n <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  pb_sink_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_en   (w_wr_en),
    .i_wr_data (bus.pb),
    .i_rd_en   (bus.rd_en),
    .o_rd_data (bus.rd_data),
    .o_empty   (bus.empty),
    .o_full    (w_full)
  );

  assign bus.full   = w_full;
  assign bus.ack_n  = r_ack_n;
  assign o_busy     = r_busy;
  assign o_byte_cnt = r_byte_cnt;
  assign o_err      = r_err;

endmodule
